// File: rtl/pio_multichannel.sv
// pio_multichannel: CHANNELS x WIDTH memory-mapped parallel I/O (sync inputs, registered outputs, optional PIO_EDGE_CAPTURE_EN edge/irq).
// Latency: loads combinational addr->rdata/sel; stores land on the next clk edge; pin inputs reach DATA_IN after two edges.
// Backpressure: none; every bus access completes in the cycle it is presented.
module pio_multichannel #(
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [31:0]               mem_rdata,
  output logic [31:0]               rdata,
  output logic                      sel,
  input  logic [CHANNELS*WIDTH-1:0] pin_in,
  output logic [CHANNELS*WIDTH-1:0] pin_out,
  output logic                      irq
);

  localparam logic [31:0] WIN_BYTES = 32'(16 * CHANNELS);

  // Window decode: offset wraps to a large value below BASE_ADDR, so one compare covers both ends.
  logic [31:0] offset;
  logic        hit;
  logic        aligned;
  logic [1:0]  reg_idx;

  assign offset  = addr - BASE_ADDR;
  assign hit     = offset < WIN_BYTES;
  assign aligned = offset[1:0] == 2'b00;
  assign reg_idx = offset[3:2];
  assign sel     = hit;

  logic [WIDTH-1:0]    data_out [CHANNELS];
  logic [WIDTH-1:0]    s1       [CHANNELS];
  logic [WIDTH-1:0]    s2       [CHANNELS];
  logic [CHANNELS-1:0] wr_ch;

`ifdef PIO_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] s3     [CHANNELS];
  logic [WIDTH-1:0] edge_q [CHANNELS];
  logic [WIDTH-1:0] irq_en [CHANNELS];
  logic [1:0]       arm_cnt;
  logic             armed;

  assign armed = arm_cnt == 2'd3;
`endif

  // Per-channel store strobe: aligned store that lands inside this channel's 16-byte block
  always_comb begin
    wr_ch = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_ch[c] = we && hit && aligned && (offset[31:4] == 28'(c));
    end
  end

  // Input synchroniser (s1 -> s2) and DATA_OUT register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        s1[c]       <= '0;
        s2[c]       <= '0;
        data_out[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        s1[c] <= pin_in[c*WIDTH +: WIDTH];
        s2[c] <= s1[c];
        if (wr_ch[c] && reg_idx == 2'd1) begin
          data_out[c] <= wdata[WIDTH-1:0];
        end
      end
    end
  end

`ifdef PIO_EDGE_CAPTURE_EN
  // Arming counter: holds off edge capture until the synchroniser has flushed reset-time zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt <= 2'd0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

  // Edge capture with W1C; a new edge wins over a simultaneous clear of the same bit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        s3[c]     <= '0;
        edge_q[c] <= '0;
        irq_en[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        s3[c] <= s2[c];
        if (wr_ch[c] && reg_idx == 2'd3) begin
          irq_en[c] <= wdata[WIDTH-1:0];
        end
        edge_q[c] <= (edge_q[c] & ~((wr_ch[c] && reg_idx == 2'd2) ? wdata[WIDTH-1:0] : '0))
                   | (armed ? (s2[c] & ~s3[c]) : '0);
      end
    end
  end

  // Interrupt: any captured edge whose mask bit is set
  always_comb begin
    irq = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      irq = irq | (|(edge_q[c] & irq_en[c]));
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Load data: selected register zero-extended on a hit, memory data on a miss
  always_comb begin
    rdata = mem_rdata;
    if (hit) begin
      rdata = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (aligned && offset[31:4] == 28'(c)) begin
          case (reg_idx)
            2'd0: rdata[WIDTH-1:0] = s2[c];
            2'd1: rdata[WIDTH-1:0] = data_out[c];
`ifdef PIO_EDGE_CAPTURE_EN
            2'd2: rdata[WIDTH-1:0] = edge_q[c];
            2'd3: rdata[WIDTH-1:0] = irq_en[c];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Port outputs straight from the DATA_OUT registers
  for (genvar c = 0; c < CHANNELS; c++) begin : g_pin_out
    assign pin_out[c*WIDTH +: WIDTH] = data_out[c];
  end

  // Store data above WIDTH is deliberately dropped
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = |wdata[31:WIDTH];
  end

endmodule

// File: tb/tb_pio_multichannel.sv
// Bench for pio_multichannel (CHANNELS=2, WIDTH=8): vector table, hand sequences, randomized model check.
// Expectations for EDGE/IRQ_EN/irq follow the build: PIO_EDGE_CAPTURE_EN selects the edge-capture behaviour.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled before the next one.
module tb_pio_multichannel;

  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef PIO_EDGE_CAPTURE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic        sel;
  logic [15:0] pin_in;
  logic [15:0] pin_out;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  pio_multichannel #(.CHANNELS(2), .WIDTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .rdata(rdata), .sel(sel), .pin_in(pin_in), .pin_out(pin_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    we = 1'b0;
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    we = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Port state as the programmer sees it, plus the pin values sampled at the last three edges.
  logic [7:0]  m_out  [2];
  logic [7:0]  m_ien  [2];
  logic [7:0]  m_edge [2];
  logic [15:0] smp_new;   // sampled at the most recent edge
  logic [15:0] smp_mid;   // sampled one edge earlier: what DATA_IN shows
  logic [15:0] smp_old;   // sampled two edges earlier
  int          live_edges; // edges since reset released, saturating at 3

  function automatic logic model_sel(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'd32;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] mem);
    logic [31:0] off;
    int ch;
    int rg;
    off = a - BASE;
    if (off >= 32'd32) return mem;
    if (off % 4 != 0) return 32'd0;
    ch = int'(off / 16);
    rg = int'((off % 16) / 4);
    case (rg)
      0: return {24'd0, smp_mid[ch*8 +: 8]};
      1: return {24'd0, m_out[ch]};
      2: return EDGE_EN ? {24'd0, m_edge[ch]} : 32'd0;
      default: return EDGE_EN ? {24'd0, m_ien[ch]} : 32'd0;
    endcase
  endfunction

  function automatic logic model_irq();
    return EDGE_EN && (|((m_edge[0] & m_ien[0]) | (m_edge[1] & m_ien[1])));
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [15:0] pins);
    logic [15:0] rise;
    logic [31:0] off;
    int ch;
    int rg;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_out[c] = 8'h0; m_ien[c] = 8'h0; m_edge[c] = 8'h0;
      end
      smp_new = 16'h0; smp_mid = 16'h0; smp_old = 16'h0;
      live_edges = 0;
      return;
    end
    rise = (live_edges >= 3) ? (smp_mid & ~smp_old) : 16'h0;
    off = a - BASE;
    ch = -1;
    rg = 0;
    if (w && off < 32'd32 && off % 4 == 0) begin
      ch = int'(off / 16);
      rg = int'((off % 16) / 4);
    end
    for (int c = 0; c < 2; c++) begin
      logic [7:0] clr;
      clr = (c == ch && rg == 2) ? wd[7:0] : 8'h0;
      m_edge[c] = (m_edge[c] & ~clr) | rise[c*8 +: 8];
      if (c == ch && rg == 1) m_out[c] = wd[7:0];
      if (c == ch && rg == 3) m_ien[c] = wd[7:0];
    end
    smp_old = smp_mid;
    smp_mid = smp_new;
    smp_new = pins;
    if (live_edges < 3) live_edges++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic        exp_sel;
    logic [31:0] exp_rdata;  // before the edge
    logic [15:0] exp_pout;   // after the edge
  } vec_t;

  vec_t vecs [16];

  logic [15:0] pins;

  initial begin
    rst = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; pin_in = 16'h0;

    vecs[0]  = '{1'b1, BASE + 32'h04, 32'h0000_00A5, 32'h0,         1'b1, 32'h0,         16'h00A5};
    vecs[1]  = '{1'b0, BASE + 32'h04, 32'h0,         32'h1234_5678, 1'b1, 32'h0000_00A5, 16'h00A5};
    vecs[2]  = '{1'b1, BASE + 32'h14, 32'hFFFF_FF5A, 32'h0,         1'b1, 32'h0,         16'h5AA5};
    vecs[3]  = '{1'b0, BASE + 32'h14, 32'h0,         32'h0,         1'b1, 32'h0000_005A, 16'h5AA5};
    vecs[4]  = '{1'b0, BASE + 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 16'h5AA5};
    vecs[5]  = '{1'b1, BASE + 32'h20, 32'h0,         32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 16'h5AA5};
    vecs[6]  = '{1'b1, BASE + 32'h05, 32'h0,         32'h0,         1'b1, 32'h0,         16'h5AA5};
    vecs[7]  = '{1'b0, BASE + 32'h04, 32'h0,         32'h0,         1'b1, 32'h0000_00A5, 16'h5AA5};
    vecs[8]  = '{1'b0, BASE - 32'h04, 32'h0,         32'h1111_1111, 1'b0, 32'h1111_1111, 16'h5AA5};
    vecs[9]  = '{1'b1, BASE + 32'h0C, 32'h0000_0081, 32'h0,         1'b1, 32'h0,         16'h5AA5};
    vecs[10] = '{1'b0, BASE + 32'h0C, 32'h0,         32'h0,         1'b1, EDGE_EN ? 32'h81 : 32'h0, 16'h5AA5};
    vecs[11] = '{1'b0, BASE + 32'h1C, 32'h0,         32'h0,         1'b1, 32'h0,         16'h5AA5};
    vecs[12] = '{1'b1, BASE + 32'h00, 32'h0000_00FF, 32'h0,         1'b1, 32'h0,         16'h5AA5};
    vecs[13] = '{1'b0, BASE + 32'h00, 32'h0,         32'h0,         1'b1, 32'h0,         16'h5AA5};
    vecs[14] = '{1'b0, BASE + 32'h10, 32'h0,         32'h0,         1'b1, 32'h0,         16'h5AA5};
    vecs[15] = '{1'b0, BASE - 32'h01, 32'h0,         32'h0000_0077, 1'b0, 32'h0000_0077, 16'h5AA5};

    // Reset state, sampled while rst is still held
    do_reset(2);
    rst = 1'b1;
    #1;
    check("reset_pin_out", {16'h0, pin_out}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rd("reset_data_out0", BASE + 32'h04, 32'h0);
    check("reset_sel", {31'h0, sel}, 32'h1);
    do_reset(1);

    // Table: bus decode, store/load, misses, unaligned and read-only behaviour
    for (int i = 0; i < 16; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata; mem_rdata = vecs[i].mem;
      #1;
      check($sformatf("vec%0d_sel", i), {31'h0, sel}, {31'h0, vecs[i].exp_sel});
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      tick();
      check($sformatf("vec%0d_pin_out", i), {16'h0, pin_out}, {16'h0, vecs[i].exp_pout});
    end
    we = 1'b0;

    // DATA_IN latency: visible two edges after the change and not before
    do_reset(2);
    pin_in = 16'h3C00;
    rd("din_before_edge", BASE + 32'h10, 32'h0);
    tick();
    rd("din_after_1_edge", BASE + 32'h10, 32'h0);
    tick();
    rd("din_after_2_edges", BASE + 32'h10, 32'h0000_003C);

    // Edge capture, irq and W1C
    wr(BASE + 32'h0C, 32'h1);
    pin_in = 16'h3C01;
    #1;
    check("irq_before_edge", {31'h0, irq}, 32'h0);
    tick();
    check("irq_after_n", {31'h0, irq}, 32'h0);
    tick();
    check("irq_after_n1", {31'h0, irq}, 32'h0);
    rd("edge_after_n1", BASE + 32'h08, 32'h0);
    tick();
    check("irq_after_n2", {31'h0, irq}, {31'h0, EDGE_EN});
    rd("edge_after_n2", BASE + 32'h08, EDGE_EN ? 32'h1 : 32'h0);
    wr(BASE + 32'h08, 32'h1);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    rd("edge_after_w1c", BASE + 32'h08, 32'h0);

    // Edge and W1C of the same bit on the same edge: the edge wins
    pin_in = 16'h3C00;
    repeat (3) tick();
    wr(BASE + 32'h08, 32'hFF);
    pin_in = 16'h3C01;
    tick();
    tick();
    wr(BASE + 32'h08, 32'h1);
    rd("edge_beats_w1c", BASE + 32'h08, EDGE_EN ? 32'h1 : 32'h0);

    // Pins held high through reset produce no edges
    pin_in = 16'hFFFF;
    do_reset(2);
    repeat (5) tick();
    rd("no_spurious_edge0", BASE + 32'h08, 32'h0);
    rd("no_spurious_edge1", BASE + 32'h18, 32'h0);
    check("no_spurious_irq", {31'h0, irq}, 32'h0);

    // Reset mid-operation wins over a concurrent store
    pin_in = 16'h0000;
    repeat (3) tick();
    wr(BASE + 32'h04, 32'hFF);
    pin_in = 16'h000F;
    repeat (3) tick();
    wr(BASE + 32'h0C, 32'h0F);
    rd("pre_rst_edge", BASE + 32'h08, EDGE_EN ? 32'h0F : 32'h0);
    check("pre_rst_irq", {31'h0, irq}, {31'h0, EDGE_EN});
    check("pre_rst_pin_out", {16'h0, pin_out}, 32'h0000_00FF);
    rst = 1'b1; we = 1'b1; addr = BASE + 32'h04; wdata = 32'hAA;
    tick();
    rst = 1'b0; we = 1'b0;
    check("rst_mid_pin_out", {16'h0, pin_out}, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    rd("rst_mid_data_out", BASE + 32'h04, 32'h0);
    rd("rst_mid_edge", BASE + 32'h08, 32'h0);
    rd("rst_mid_ien", BASE + 32'h0C, 32'h0);
    rd("rst_mid_data_in", BASE + 32'h00, 32'h0);

    // Randomized traffic against the reference model
    rst = 1'b1; we = 1'b0; pins = 16'h0; pin_in = pins;
    @(posedge clk);
    model_edge(1'b1, 1'b0, 32'h0, 32'h0, pins);
    #1;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        8: addr = BASE + 32'($urandom_range(0, 31));
        9: addr = $urandom;
        default: addr = BASE + 32'($urandom_range(0, 7)) * 32'd4;
      endcase
      wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
      mem_rdata = $urandom;
      if ($urandom_range(0, 2) == 0) pins = pins ^ (16'h1 << $urandom_range(0, 15));
      pin_in = pins;
      #1;
      check("rnd_sel", {31'h0, sel}, {31'h0, model_sel(addr)});
      check("rnd_rdata", rdata, model_read(addr, mem_rdata));
      check("rnd_pin_out", {16'h0, pin_out}, {16'h0, m_out[1], m_out[0]});
      check("rnd_irq", {31'h0, irq}, {31'h0, model_irq()});
      @(posedge clk);
      model_edge(rst, we, addr, wdata, pins);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
